display_timings_locked: RTL and testbench

- Display timing generator clocked by the 65 MHz pixel clock from the clock-generation block.
- Consumes that block's locked flag and holds all video timing idle until the clock has been stably locked.
- Produces sync, data-enable and screen coordinates for 1024x768@60 (XGA), or any mode set by parameters.
- Drops back to idle on loss of lock; sits between clock generation and the pixel pipeline/TMDS path.

---
 rtl/display_timings_locked.sv | 194 +++++++++++++++++++
 tb/tb_display_timings_locked.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_timings_locked.sv
// XGA-class display timing generator that stays idle until the pixel-clock lock flag has been stable for SETTLE_CYCLES.
// Optional lock-loss counter is built when DISPLAY_TIMINGS_LOSS_COUNT_EN is defined.
module display_timings_locked #(
    parameter int   CORDW         = 16,
    parameter int   H_RES         = 1024,
    parameter int   H_FP          = 24,
    parameter int   H_SYNC        = 136,
    parameter int   H_BP          = 160,
    parameter int   V_RES         = 768,
    parameter int   V_FP          = 3,
    parameter int   V_SYNC        = 6,
    parameter int   V_BP          = 29,
    parameter logic H_POL         = 1'b0,
    parameter logic V_POL         = 1'b0,
    parameter int   SETTLE_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_locked,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic             o_frame,
    output logic             o_line,
    output logic [CORDW-1:0] o_sx,
    output logic [CORDW-1:0] o_sy,
    output logic             o_running,
    output logic [7:0]       o_loss_count
);

    localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOT - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOT - 1);
    localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_BEG   = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_BEG   = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);
    localparam logic [SW-1:0]    SET_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    function automatic logic in_span(input logic [CORDW-1:0] pos,
                                     input logic [CORDW-1:0] beg,
                                     input logic [CORDW-1:0] fin);
        return (pos >= beg) && (pos < fin);
    endfunction

    logic             lk_meta_r, lk_r;
    state_t           state_r, state_s;
    logic [SW-1:0]    settle_cnt_r, settle_cnt_s;
    logic [CORDW-1:0] sx_r, sy_r, sx_s, sy_s;
    logic             hs_r, vs_r, de_r, frame_r, line_r, run_r;
    logic             hs_s, vs_s, de_s, frame_s, line_s, run_s;

    // Two-flop synchroniser for the asynchronous lock flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lk_meta_r <= 1'b0;
            lk_r      <= 1'b0;
        end else begin
            lk_meta_r <= i_locked;
            lk_r      <= lk_meta_r;
        end
    end

    // Next state, next position and the timing outputs describing that position
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        sx_s         = {CORDW{1'b0}};
        sy_s         = {CORDW{1'b0}};
        case (state_r)
            ST_WAIT: begin
                if (lk_r) begin
                    state_s      = ST_SETTLE;
                    settle_cnt_s = {SW{1'b0}};
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (!lk_r) begin
                    state_s      = ST_WAIT;
                    settle_cnt_s = {SW{1'b0}};
                end else if (settle_cnt_r == SET_LAST) begin
                    state_s      = ST_RUN;
                    settle_cnt_s = {SW{1'b0}};
                end else begin
                    settle_cnt_s = settle_cnt_r + SW'(1);
                end
            end
            ST_RUN: begin
                // A lost lock drops straight to idle; the position stays at the 0/0 default
                if (!lk_r) begin
                    state_s = ST_WAIT;
                end else if (sx_r == H_LAST) begin
                    sx_s = {CORDW{1'b0}};
                    if (sy_r == V_LAST) begin
                        sy_s = {CORDW{1'b0}};
                    end else begin
                        sy_s = sy_r + CORDW'(1);
                    end
                end else begin
                    sx_s = sx_r + CORDW'(1);
                    sy_s = sy_r;
                end
            end
            default: begin
                state_s      = ST_WAIT;
                settle_cnt_s = {SW{1'b0}};
            end
        endcase

        run_s   = (state_s == ST_RUN);
        de_s    = run_s && (sx_s < H_ACT) && (sy_s < V_ACT);
        frame_s = run_s && (sx_s == {CORDW{1'b0}}) && (sy_s == {CORDW{1'b0}});
        line_s  = run_s && (sx_s == {CORDW{1'b0}});
        if (run_s && in_span(sx_s, HS_BEG, HS_END)) begin
            hs_s = H_POL;
        end else begin
            hs_s = ~H_POL;
        end
        if (run_s && in_span(sy_s, VS_BEG, VS_END)) begin
            vs_s = V_POL;
        end else begin
            vs_s = ~V_POL;
        end
    end

    // State, counters and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_WAIT;
            settle_cnt_r <= {SW{1'b0}};
            sx_r         <= {CORDW{1'b0}};
            sy_r         <= {CORDW{1'b0}};
            hs_r         <= ~H_POL;
            vs_r         <= ~V_POL;
            de_r         <= 1'b0;
            frame_r      <= 1'b0;
            line_r       <= 1'b0;
            run_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            sx_r         <= sx_s;
            sy_r         <= sy_s;
            hs_r         <= hs_s;
            vs_r         <= vs_s;
            de_r         <= de_s;
            frame_r      <= frame_s;
            line_r       <= line_s;
            run_r        <= run_s;
        end
    end

`ifdef DISPLAY_TIMINGS_LOSS_COUNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating count of RUN->WAIT transitions, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            loss_cnt_r <= 8'd0;
        end else if ((state_r == ST_RUN) && !lk_r && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign o_loss_count = loss_cnt_r;
`else
    assign o_loss_count = 8'd0;
`endif

    assign o_hs      = hs_r;
    assign o_vs      = vs_r;
    assign o_de      = de_r;
    assign o_frame   = frame_r;
    assign o_line    = line_r;
    assign o_sx      = sx_r;
    assign o_sy      = sy_r;
    assign o_running = run_r;

endmodule

// File: tb/tb_display_timings_locked.sv
// Bench for display_timings_locked using a reduced video mode (25x13 totals) so whole frames fit in a short run.
// A position-from-elapsed-time model is compared every cycle, plus hand-computed literal checks.
module tb_display_timings_locked;

    localparam int CORDW = 16;
    localparam int H_RES = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
    localparam int V_RES = 8,  V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int S     = 16;
    localparam int HT    = 25;
    localparam int VT    = 13;
    localparam int FRAME = 325;
`ifdef DISPLAY_TIMINGS_LOSS_COUNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             locked = 1'b0;
    logic             hs, vs, de, frame, line, running;
    logic [CORDW-1:0] sx, sy;
    logic [7:0]       loss;

    int n_cmp = 0;
    int n_bad = 0;

    display_timings_locked #(
        .CORDW(CORDW), .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(1'b0), .V_POL(1'b0), .SETTLE_CYCLES(S)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked),
        .o_hs(hs), .o_vs(vs), .o_de(de), .o_frame(frame), .o_line(line),
        .o_sx(sx), .o_sy(sy), .o_running(running), .o_loss_count(loss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: lock seen two edges late; RUN after S+1 consecutive seen-high edges; position from elapsed RUN cycles
    bit m_h0, m_h1, m_run;
    int m_streak, m_t, m_loss;

    always @(posedge clk or negedge rst_n) begin
        bit lk;
        if (!rst_n) begin
            m_h0 = 1'b0; m_h1 = 1'b0; m_run = 1'b0;
            m_streak = 0; m_t = 0; m_loss = 0;
        end else begin
            lk = m_h1;
            m_h1 = m_h0;
            m_h0 = locked;
            if (m_run) begin
                if (!lk) begin
                    m_run = 1'b0;
                    m_streak = 0;
                    if (LC_EN && m_loss < 255) m_loss++;
                end else begin
                    m_t = (m_t + 1) % FRAME;
                end
            end else if (lk) begin
                m_streak++;
                if (m_streak == S + 1) begin
                    m_run = 1'b1;
                    m_t = 0;
                end
            end else begin
                m_streak = 0;
            end
        end
    end

    function automatic logic [63:0] model_vec();
        int ex, ey;
        logic e_hs, e_vs, e_de, e_fr, e_ln;
        ex = m_run ? m_t % HT : 0;
        ey = m_run ? m_t / HT : 0;
        e_hs = !(m_run && ex >= H_RES + H_FP && ex < H_RES + H_FP + H_SYNC);
        e_vs = !(m_run && ey >= V_RES + V_FP && ey < V_RES + V_FP + V_SYNC);
        e_de = m_run && ex < H_RES && ey < V_RES;
        e_fr = m_run && m_t == 0;
        e_ln = m_run && ex == 0;
        return {18'd0, m_run, ex[15:0], ey[15:0], e_hs, e_vs, e_de, e_fr, e_ln, m_loss[7:0]};
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("model_outputs", {18'd0, running, sx, sy, hs, vs, de, frame, line, loss}, model_vec());
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check(name, {running, sx, sy, hs, vs, de, frame, line}, {1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_line, n_de, n_hs, n_vs, n_fr;
        bit ok;

        // Reset state before any clock edge
        #2 rst_n = 1'b0;
        #1 check_idle("reset_idle");
        check("reset_loss", loss, 8'd0);
        locked = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;

        // Lock held from reset release: RUN appears after edge 19
        tick(18);
        check("not_running_edge18", running, 1'b0);
        tick(1);
        check("first_run_cycle", {running, sx, sy, frame, line, de, hs, vs},
              {1'b1, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

        // One full frame of pulse/level counts
        n_line = 0; n_de = 0; n_hs = 0; n_vs = 0; n_fr = 0;
        for (int i = 0; i < FRAME; i++) begin
            n_line += int'(line);
            n_de   += int'(de);
            n_hs   += int'(!hs);
            n_vs   += int'(!vs);
            n_fr   += int'(frame);
            if (i == 17) check("hs_before_sync", hs, 1'b1);
            if (i == 18) check("hs_sync_start", hs, 1'b0);
            if (i == 22) check("hs_after_sync", hs, 1'b1);
            tick(1);
        end
        check("line_pulses", n_line, 13);
        check("de_cycles", n_de, 128);
        check("hs_low_cycles", n_hs, 52);
        check("vs_low_cycles", n_vs, 50);
        check("frame_pulses", n_fr, 1);
        check("frame_period", {frame, sx, sy}, {1'b1, 16'd0, 16'd0});

        // Lock drop at (10,5): idle three edges after the input falls
        tick(135);
        check("drop_pos", {sx, sy}, {16'd10, 16'd5});
        locked = 1'b0;
        tick(2);
        check("still_running", {running, sx, sy}, {1'b1, 16'd12, 16'd5});
        tick(1);
        check_idle("idle_after_drop");
        check("loss_after_drop", loss, LC_EN ? 8'd1 : 8'd0);
        locked = 1'b1;
        tick(18);
        check("relock_wait", running, 1'b0);
        tick(1);
        check("relock_restart", {running, sx, sy, frame}, {1'b1, 16'd0, 16'd0, 1'b1});

        // Asynchronous reset mid-frame at (20,10) with both syncs active
        tick(270);
        check("pre_reset_pos", {sx, sy, hs, vs}, {16'd20, 16'd10, 1'b0, 1'b0});
        #1 rst_n = 1'b0;
        #1 check_idle("async_reset_idle");
        check("async_reset_loss", loss, 8'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(18);
        check("post_reset_wait", running, 1'b0);
        tick(1);
        check("post_reset_run", {running, frame}, {1'b1, 1'b1});

        // Lock glitch during SETTLE at count 10
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        tick(11);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(18);
        check("glitch_wait", running, 1'b0);
        tick(1);
        check("glitch_run", {running, sx, sy, frame}, {1'b1, 16'd0, 16'd0, 1'b1});

        // 260 lock-loss events
        rst_n = 1'b0; locked = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 260; k++) begin
            locked = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 40 && !ok; c++) begin
                tick(1);
                ok = running;
            end
            if (!ok) check("wait_running_timeout", 1'b0, 1'b1);
            locked = 1'b0;
            tick(4);
        end
        check("loss_saturated", loss, LC_EN ? 8'd255 : 8'd0);
        check_idle("final_idle");

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
